// File: rtl/weight_arb_pkg.sv
// weight_arb_pkg: shared FSM states, ROM latency default and round-robin pick for the weight ROM arbiter
package weight_arb_pkg;
  typedef enum logic [1:0] {IDLE, ARB, STREAM, DRAIN} state_e;
  localparam int ROM_LATENCY_DEF = 2;
  // First set bit of pend at or after ptr, scanning modulo n; returns ptr when none is set.
  function automatic int rr_pick(input logic [31:0] pend, input int n, input int ptr);
    rr_pick = ptr;
    for (int k = n - 1; k >= 0; k--)
      if (pend[5'((ptr + k) % n)]) rr_pick = (ptr + k) % n;
  endfunction
endpackage

// File: rtl/weight_arb_fifo.sv
// weight_arb_fifo: synchronous FIFO with same-cycle push/pop, legal even when full
// Ports: clk, rst (sync, active-high), push/din write side, pop/dout read side (dout = head),
//        count occupancy, full, empty.
module weight_arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (rd) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/weight_rom_stream_arbiter.sv
// weight_rom_stream_arbiter: round-robin sharing of one pipelined weight ROM read port between NUM_REQ streams
// Ports: clk, rst (sync, active-high); req_start/req_base/req_len per-requester pass request;
//        req_busy, req_done per-requester status; rom_addr/rom_ce/rom_q ROM port;
//        data_out (shared bus), data_out_valid (one-hot), data_out_ready per-requester handshake;
//        grant_idx current/last granted requester.
// Optional macro WEIGHT_ARB_PERF_EN adds perf_stall_cnt, per-requester saturating 32-bit stall counters.
module weight_rom_stream_arbiter import weight_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH = 576,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH) + 1,
  parameter int IDX_WIDTH = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_start,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]            req_busy,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  output logic                          rom_ce,
  input  logic [DATA_WIDTH-1:0]         rom_q,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic [NUM_REQ-1:0]            data_out_valid,
  input  logic [NUM_REQ-1:0]            data_out_ready,
`ifdef WEIGHT_ARB_PERF_EN
  output logic [NUM_REQ*32-1:0]         perf_stall_cnt,
`endif
  output logic [IDX_WIDTH-1:0]          grant_idx
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_e state, state_n;
  logic [NUM_REQ-1:0] pending;
  logic [ADDR_WIDTH-1:0] base_r [NUM_REQ];
  logic [ADDR_WIDTH-1:0] len_r [NUM_REQ];
  logic [IDX_WIDTH-1:0] rr_ptr, win;
  logic [ADDR_WIDTH-1:0] issue_cnt, dlv_cnt;
  logic [ROM_LATENCY-1:0] tag;
  logic [CW-1:0] count;
  logic full, empty, issue, pop, active, done;
  generate
    if (FIFO_DEPTH < ROM_LATENCY + 1) begin : g_depth_chk
      $error("FIFO_DEPTH must be at least ROM_LATENCY+1");
    end
  endgenerate
  assign rom_ce = 1'b1;
  assign win = IDX_WIDTH'(rr_pick(32'(pending), NUM_REQ, int'(rr_ptr)));
  assign active = state == STREAM || state == DRAIN;
  // Credit: every issued word already has a FIFO slot reserved, counting words still in the ROM pipe.
  assign issue = state == STREAM && issue_cnt != '0 && !full && int'(count) + $countones(tag) < FIFO_DEPTH;
  assign pop = !empty && data_out_ready[grant_idx];
  assign done = state == DRAIN && dlv_cnt == '0 && empty;
  assign req_busy = pending | (NUM_REQ'(active) << grant_idx);
  assign req_done = NUM_REQ'(done) << grant_idx;
  assign data_out_valid = NUM_REQ'(!empty) << grant_idx;
  weight_arb_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tag[ROM_LATENCY-1]),
    .din(rom_q),
    .pop(pop),
    .dout(data_out),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = |pending ? ARB : IDLE;
      ARB:     state_n = len_r[win] == '0 ? DRAIN : STREAM;
      STREAM:  state_n = issue_cnt == '0 ? DRAIN : STREAM;
      DRAIN:   state_n = done ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      rr_ptr <= '0;
      grant_idx <= '0;
      rom_addr <= '0;
      issue_cnt <= '0;
      dlv_cnt <= '0;
      tag <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        base_r[i] <= '0;
        len_r[i] <= '0;
      end
    end else begin
      state <= state_n;
      // rom_addr is presented combinationally to the ROM, so the tag tracks the data ROM_LATENCY cycles behind it.
      tag <= (tag << 1) | ROM_LATENCY'(issue);
      for (int i = 0; i < NUM_REQ; i++)
        if (req_start[i] && !req_busy[i]) begin
          pending[i] <= 1'b1;
          base_r[i] <= req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
          len_r[i] <= req_len[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
      if (state == ARB) begin
        pending[win] <= 1'b0;
        grant_idx <= win;
        rom_addr <= base_r[win];
        issue_cnt <= len_r[win];
        dlv_cnt <= len_r[win];
        rr_ptr <= win == IDX_WIDTH'(NUM_REQ - 1) ? '0 : win + 1'b1;
      end
      if (issue) begin
        rom_addr <= rom_addr == ADDR_WIDTH'(DEPTH - 1) ? '0 : rom_addr + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (pop) dlv_cnt <= dlv_cnt - 1'b1;
    end
  end
`ifdef WEIGHT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (rst) perf_stall_cnt[i*32 +: 32] <= '0;
      else if (req_busy[i] && !(data_out_valid[i] && data_out_ready[i]) && perf_stall_cnt[i*32 +: 32] != '1)
        perf_stall_cnt[i*32 +: 32] <= perf_stall_cnt[i*32 +: 32] + 1'b1;
  end
`endif
endmodule
